// File: rtl/div_bcd_pkg.sv
// Shared types and constants for the quotient-to-BCD converter.
package div_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int          IN_WIDTH_DEF = 16;
  localparam logic [3:0]  ERR_CODE_DEF = 4'hF;

  // Smallest digit count whose decimal range covers every IN_WIDTH-bit value.
  function automatic int digits_for(input int w);
    longint maxv;
    longint p;
    int     d;
    maxv = (64'd1 << w) - 64'd1;
    p    = 10;
    d    = 1;
    while (p <= maxv) begin
      p = p * 10;
      d = d + 1;
    end
    return d;
  endfunction

  localparam int DIGITS_DEF = digits_for(IN_WIDTH_DEF);
  localparam int CNT_W_DEF  = $clog2(IN_WIDTH_DEF + 1);

endpackage

// File: rtl/div_quotient_bcd_if.sv
// Handshake bundle between divider, BCD converter and display driver.
interface div_quotient_bcd_if #(
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           quotient;
  logic                  div_error;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  out_err;
  logic                  busy;

  modport slave (
    input  in_valid, quotient, div_error, out_ready,
    output in_ready, out_valid, bcd, out_err, busy
  );

  modport master (
    output in_valid, quotient, div_error, out_ready,
    input  in_ready, out_valid, bcd, out_err, busy
  );
endinterface

// File: rtl/bcd_add3_cell.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3_cell (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/div_quotient_bcd.sv
// Serial binary-to-BCD of the divider quotient, one bit per clock (IN_WIDTH cycles, 1 on error).
// Single result slot: input is refused until the held result is taken by out_ready.
module div_quotient_bcd
  import div_bcd_pkg::*;
#(
  parameter int         IN_WIDTH = IN_WIDTH_DEF,
  parameter int         DIGITS   = DIGITS_DEF,
  parameter logic [3:0] ERR_CODE = ERR_CODE_DEF
) (
  input logic               clk,
  input logic               rst_n,
  div_quotient_bcd_if.slave bus
);

  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + IN_WIDTH;

  state_e          state_q,     state_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic [SW-1:0]   shift_q,     shift_d;
  logic [BW-1:0]   bcd_q,       bcd_d;
  logic            out_err_q,   out_err_d;
  logic            in_ready_q,  in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q,      busy_d;

  logic [BW-1:0]   adj;
  logic [SW-1:0]   shifted;
  logic            unused_quotient_hi;

  // Sign replicas above IN_WIDTH never reach the datapath.
  assign unused_quotient_hi = ^bus.quotient[31:IN_WIDTH];

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_cell u_cell (
      .din  (shift_q[IN_WIDTH + 4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  assign shifted = {adj, shift_q[IN_WIDTH-1:0]} << 1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    out_err_d   = out_err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (bus.div_error) begin
            bcd_d       = {DIGITS{ERR_CODE}};
            out_err_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            shift_d = {{BW{1'b0}}, bus.quotient[IN_WIDTH-1:0]};
            cnt_d   = CW'(IN_WIDTH);
            busy_d  = 1'b1;
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        shift_d = shifted;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d       = shifted[SW-1:IN_WIDTH];
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // No overlap: the slot reopens only on the cycle after consumption.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      bcd_q       <= '0;
      out_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      out_err_q   <= out_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bcd       = bcd_q;
  assign bus.out_err   = out_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_div_quotient_bcd.sv
// Directed bench for div_quotient_bcd with hand-computed BCD results.
module tb_div_quotient_bcd;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   edges;
  int   busy_n;

  div_quotient_bcd_if #(.DIGITS(5)) bus ();

  div_quotient_bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [31:0] q, input logic e);
    bus.in_valid  = 1'b1;
    bus.quotient  = q;
    bus.div_error = e;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.quotient  = 32'hDEAD_BEEF;
    bus.div_error = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid is seen, bounded.
  task automatic wait_out(output int n, output int b);
    n = 0;
    b = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) b++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.quotient  = '0;
    bus.div_error = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_bcd",       64'(bus.bcd),       64'd0);
    check("rst_out_err",   64'(bus.out_err),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1234 with immediate consumption
    send(32'h0000_04D2, 1'b0);
    check("t1_busy",     64'(bus.busy),     64'd1);
    check("t1_in_ready", 64'(bus.in_ready), 64'd0);
    wait_out(edges, busy_n);
    check("t1_latency",  64'(edges),       64'd16);
    check("t1_bcd",      64'(bus.bcd),     64'h01234);
    check("t1_out_err",  64'(bus.out_err), 64'd0);
    check("t1_rdy_held", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    check("t1_consumed", 64'(bus.out_valid), 64'd0);
    check("t1_rdy_back", 64'(bus.in_ready),  64'd1);

    // maximum value and sign-replica immunity
    send(32'hFFFF_FFFF, 1'b0);
    wait_out(edges, busy_n);
    check("t2_max_bcd", 64'(bus.bcd), 64'h65535);
    @(posedge clk); #1;
    send(32'hFFFF_8000, 1'b0);
    wait_out(edges, busy_n);
    check("t2_32768_bcd", 64'(bus.bcd), 64'h32768);
    @(posedge clk); #1;

    // zero runs full length with busy throughout
    send(32'h0000_0000, 1'b0);
    wait_out(edges, busy_n);
    check("t3_latency",  64'(edges),   64'd16);
    check("t3_busy_cyc", 64'(busy_n),  64'd16);
    check("t3_bcd",      64'(bus.bcd), 64'h00000);
    @(posedge clk); #1;

    // divide-by-zero path
    send(32'h1234_5678, 1'b1);
    wait_out(edges, busy_n);
    check("t4_latency", 64'(edges),       64'd0);
    check("t4_bcd",     64'(bus.bcd),     64'hFFFFF);
    check("t4_out_err", 64'(bus.out_err), 64'd1);
    @(posedge clk); #1;
    check("t4_consumed", 64'(bus.out_valid), 64'd0);

    // backpressure hold with an ignored input pulse
    bus.out_ready = 1'b0;
    send(32'h0000_04D2, 1'b0);
    wait_out(edges, busy_n);
    check("t5_latency", 64'(edges), 64'd16);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        bus.in_valid = 1'b1;
        bus.quotient = 32'h0000_0007;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("t5_hold_valid", 64'(bus.out_valid), 64'd1);
      check("t5_hold_bcd",   64'(bus.bcd),       64'h01234);
      check("t5_hold_rdy",   64'(bus.in_ready),  64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_consumed", 64'(bus.out_valid), 64'd0);
    check("t5_rdy_back", 64'(bus.in_ready),  64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_second", 64'(bus.out_valid), 64'd0);
    check("t5_no_busy",   64'(bus.busy),      64'd0);

    // asynchronous reset mid-conversion, then a clean run
    send(32'h0000_270F, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    check("t6_busy_pre", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",  64'(bus.busy),      64'd0);
    check("t6_rst_rdy",   64'(bus.in_ready),  64'd1);
    check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    check("t6_rst_bcd",   64'(bus.bcd),       64'd0);
    check("t6_rst_err",   64'(bus.out_err),   64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_idle_rdy",   64'(bus.in_ready),  64'd1);
    check("t6_idle_valid", 64'(bus.out_valid), 64'd0);
    send(32'h0000_002A, 1'b0);
    wait_out(edges, busy_n);
    check("t6_latency", 64'(edges),   64'd16);
    check("t6_bcd",     64'(bus.bcd), 64'h00042);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
